// File: rtl/viterbi_pkg.sv
// Shared constants, FSM state type and modulo-11 index helpers for the survivor-bank sequencer.
package viterbi_pkg;

    localparam int unsigned NUM_BANKS = 11;
    localparam int unsigned IDX_W     = 4;

    typedef enum logic [1:0] {
        StIdle,
        StTbReq,
        StTbRun
    } tb_state_e;

    function automatic logic [IDX_W-1:0] inc_mod11(input logic [IDX_W-1:0] x);
        return (x == IDX_W'(NUM_BANKS - 1)) ? '0 : x + 1'b1;
    endfunction

    function automatic logic [IDX_W-1:0] dec_mod11(input logic [IDX_W-1:0] x);
        return (x == '0) ? IDX_W'(NUM_BANKS - 1) : x - 1'b1;
    endfunction

endpackage

// File: rtl/decode_4to11.sv
// Bank index to one-hot bank enable, forced to zero when not enabled.
module decode_4to11
    import viterbi_pkg::*;
(
    input  logic [IDX_W-1:0]     idx,
    input  logic                 en,
    output logic [NUM_BANKS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int unsigned i = 0; i < NUM_BANKS; i++) begin
            onehot[i] = en && (idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/viterbi_bank_sequencer.sv
// Circular bank allocator for the Viterbi survivor memory: assigns writes to free banks,
// schedules tracebacks over the newest banks and releases the oldest decoded ones.
module viterbi_bank_sequencer
    import viterbi_pkg::*;
#(
    parameter int unsigned TB_LEN  = 6,
    parameter int unsigned DEC_LEN = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sym_valid,
    output logic                 sym_ready,
    output logic                 wr_en,
    output logic [IDX_W-1:0]     wr_idx,
    output logic [NUM_BANKS-1:0] wr_onehot,
    input  logic                 flush,
    output logic                 tb_req,
    input  logic                 tb_ack,
    output logic [IDX_W-1:0]     tb_start,
    output logic [IDX_W-1:0]     tb_len,
    output logic                 rd_en,
    output logic [IDX_W-1:0]     rd_idx,
    output logic [NUM_BANKS-1:0] rd_onehot,
    output logic                 dec_valid,
    output logic [IDX_W-1:0]     count
);

    if (TB_LEN < 2 || TB_LEN > NUM_BANKS) begin : g_bad_tb_len
        $error("TB_LEN must lie in 2..11");
    end
    if (DEC_LEN < 1 || DEC_LEN >= TB_LEN) begin : g_bad_dec_len
        $error("DEC_LEN must lie in 1..TB_LEN-1");
    end

    localparam logic [IDX_W-1:0] TB_LEN_W  = IDX_W'(TB_LEN);
    localparam logic [IDX_W-1:0] DEC_LEN_W = IDX_W'(DEC_LEN);

    tb_state_e        state;
    logic [IDX_W-1:0] wr_ptr;
    logic [IDX_W-1:0] count_q;
    logic [IDX_W-1:0] count_d;
    logic [IDX_W-1:0] rd_ptr;
    logic [IDX_W-1:0] step;
    logic [IDX_W-1:0] len_q;
    logic [IDX_W-1:0] rel_q;
    logic [IDX_W-1:0] tb_start_q;
    logic             tb_req_q;
    logic             rd_en_q;
    logic             last_step;
    logic             release_now;

    assign sym_ready   = count_q < IDX_W'(NUM_BANKS);
    assign wr_en       = sym_valid & sym_ready;
    assign wr_idx      = wr_ptr;
    assign rd_idx      = rd_ptr;
    assign rd_en       = rd_en_q;
    assign tb_req      = tb_req_q;
    assign tb_start    = tb_start_q;
    assign tb_len      = len_q;
    assign count       = count_q;
    assign last_step   = (step == len_q - 1'b1);
    assign release_now = rd_en_q & last_step;
    // The oldest R banks of the window are the last R steps of the backward walk.
    assign dec_valid   = rd_en_q & (step >= len_q - rel_q);

    always_comb begin
        count_d = count_q;
        if (wr_en) begin
            count_d = count_d + 1'b1;
        end
        if (release_now) begin
            count_d = count_d - rel_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            wr_ptr     <= '0;
            count_q    <= '0;
            rd_ptr     <= '0;
            step       <= '0;
            len_q      <= '0;
            rel_q      <= '0;
            tb_start_q <= '0;
            tb_req_q   <= 1'b0;
            rd_en_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            if (wr_en) begin
                wr_ptr <= inc_mod11(wr_ptr);
            end
            unique case (state)
                StIdle: begin
                    if (count_q >= TB_LEN_W) begin
                        state      <= StTbReq;
                        tb_req_q   <= 1'b1;
                        len_q      <= TB_LEN_W;
                        rel_q      <= DEC_LEN_W;
                        tb_start_q <= dec_mod11(wr_ptr);
                    end else if (flush && count_q != '0) begin
                        // End of frame: walk and release every filled bank.
                        state      <= StTbReq;
                        tb_req_q   <= 1'b1;
                        len_q      <= count_q;
                        rel_q      <= count_q;
                        tb_start_q <= dec_mod11(wr_ptr);
                    end
                end
                StTbReq: begin
                    if (tb_ack) begin
                        state    <= StTbRun;
                        tb_req_q <= 1'b0;
                        rd_en_q  <= 1'b1;
                        rd_ptr   <= tb_start_q;
                        step     <= '0;
                    end
                end
                StTbRun: begin
                    rd_ptr <= dec_mod11(rd_ptr);
                    step   <= step + 1'b1;
                    if (last_step) begin
                        state   <= StIdle;
                        rd_en_q <= 1'b0;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    decode_4to11 u_wr_dec (
        .idx    (wr_ptr),
        .en     (wr_en),
        .onehot (wr_onehot)
    );

    decode_4to11 u_rd_dec (
        .idx    (rd_ptr),
        .en     (rd_en_q),
        .onehot (rd_onehot)
    );

endmodule

// File: tb/tb_viterbi_bank_sequencer.sv
// Bench for viterbi_bank_sequencer: write-path vector table plus traceback read scoreboard.
module tb_viterbi_bank_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        sym_valid;
    logic        sym_ready;
    logic        wr_en;
    logic [3:0]  wr_idx;
    logic [10:0] wr_onehot;
    logic        flush;
    logic        tb_req;
    logic        tb_ack;
    logic [3:0]  tb_start;
    logic [3:0]  tb_len;
    logic        rd_en;
    logic [3:0]  rd_idx;
    logic [10:0] rd_onehot;
    logic        dec_valid;
    logic [3:0]  count;

    int n_vec = 0;
    int n_bad = 0;

    int exp_idx[$];
    int exp_dec[$];
    int mon_idx;
    int mon_dec;

    typedef struct {
        logic valid;
        logic wr_en;
        int   idx;
        int   onehot;
        int   count;
        logic ready;
        logic req;
    } wvec_t;

    wvec_t vec[14];

    viterbi_bank_sequencer #(
        .TB_LEN  (6),
        .DEC_LEN (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_onehot (wr_onehot),
        .flush     (flush),
        .tb_req    (tb_req),
        .tb_ack    (tb_ack),
        .tb_start  (tb_start),
        .tb_len    (tb_len),
        .rd_en     (rd_en),
        .rd_idx    (rd_idx),
        .rd_onehot (rd_onehot),
        .dec_valid (dec_valid),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected reads walk backwards from start; the last rel steps lie in the decode region.
    task automatic push_tb(input int start, input int n, input int len, input int rel);
        for (int s = 0; s < n; s++) begin
            int v;
            v = start - s;
            if (v < 0) v += 11;
            exp_idx.push_back(v);
            exp_dec.push_back((s >= len - rel) ? 1 : 0);
        end
    endtask

    task automatic apply(input int i);
        sym_valid = vec[i].valid;
        @(negedge clk);
        check($sformatf("v%0d wr_en", i), wr_en, vec[i].wr_en);
        check($sformatf("v%0d wr_idx", i), wr_idx, vec[i].idx);
        check($sformatf("v%0d wr_onehot", i), wr_onehot, vec[i].onehot);
        check($sformatf("v%0d count", i), count, vec[i].count);
        check($sformatf("v%0d sym_ready", i), sym_ready, vec[i].ready);
        check($sformatf("v%0d tb_req", i), tb_req, vec[i].req);
        tick();
    endtask

    always @(negedge clk) begin
        if (rd_en === 1'b1) begin
            if (exp_idx.size() == 0) begin
                check("unexpected rd_en", rd_en, 0);
            end else begin
                mon_idx = exp_idx.pop_front();
                mon_dec = exp_dec.pop_front();
                check("rd_idx", rd_idx, mon_idx);
                check("rd_onehot", rd_onehot, 1 << mon_idx);
                check("dec_valid", dec_valid, mon_dec);
            end
        end else begin
            check("idle rd outputs", {dec_valid, rd_onehot}, 0);
        end
    end

    initial begin
        // Six writes from reset, then the stall-to-full run across the 10->0 wrap.
        vec[0]  = '{1'b1, 1'b1, 0, 1, 0, 1'b1, 1'b0};
        vec[1]  = '{1'b1, 1'b1, 1, 2, 1, 1'b1, 1'b0};
        vec[2]  = '{1'b1, 1'b1, 2, 4, 2, 1'b1, 1'b0};
        vec[3]  = '{1'b1, 1'b1, 3, 8, 3, 1'b1, 1'b0};
        vec[4]  = '{1'b1, 1'b1, 4, 16, 4, 1'b1, 1'b0};
        vec[5]  = '{1'b1, 1'b1, 5, 32, 5, 1'b1, 1'b0};
        vec[6]  = '{1'b1, 1'b1, 6, 64, 4, 1'b1, 1'b0};
        vec[7]  = '{1'b1, 1'b1, 7, 128, 5, 1'b1, 1'b0};
        vec[8]  = '{1'b1, 1'b1, 8, 256, 6, 1'b1, 1'b0};
        vec[9]  = '{1'b1, 1'b1, 9, 512, 7, 1'b1, 1'b1};
        vec[10] = '{1'b1, 1'b1, 10, 1024, 8, 1'b1, 1'b1};
        vec[11] = '{1'b1, 1'b1, 0, 1, 9, 1'b1, 1'b1};
        vec[12] = '{1'b1, 1'b1, 1, 2, 10, 1'b1, 1'b1};
        vec[13] = '{1'b1, 1'b0, 2, 0, 11, 1'b0, 1'b1};

        rst = 1'b1;
        sym_valid = 1'b0;
        flush = 1'b0;
        tb_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst count", count, 0);
        check("rst sym_ready", sym_ready, 1);
        check("rst tb_req", tb_req, 0);
        check("rst rd_en", rd_en, 0);
        check("rst wr_onehot", wr_onehot, 0);
        check("rst tb_start", tb_start, 0);
        check("rst tb_len", tb_len, 0);
        tick();
        rst = 1'b0;

        for (int i = 0; i < 6; i++) apply(i);
        sym_valid = 1'b0;
        @(negedge clk);
        check("t1 count", count, 6);
        check("t1 tb_req early", tb_req, 0);
        tick();
        @(negedge clk);
        check("t2 tb_req", tb_req, 1);
        check("t2 tb_start", tb_start, 5);
        check("t2 tb_len", tb_len, 6);
        tb_ack = 1'b1;
        push_tb(5, 6, 6, 2);
        tick();
        tb_ack = 1'b0;
        repeat (6) tick();
        @(negedge clk);
        check("tb1 count", count, 4);
        check("tb1 rd_en", rd_en, 0);
        check("tb1 reads left", exp_idx.size(), 0);
        tick();

        for (int i = 6; i < 14; i++) apply(i);
        @(negedge clk);
        check("full tb_req held", tb_req, 1);
        check("full tb_start", tb_start, 7);
        check("full tb_len", tb_len, 6);
        check("full count", count, 11);
        check("full sym_ready", sym_ready, 0);
        tb_ack = 1'b1;
        push_tb(7, 6, 6, 2);
        tick();
        tb_ack = 1'b0;
        repeat (6) tick();
        @(negedge clk);
        check("rel count", count, 9);
        check("rel sym_ready", sym_ready, 1);
        check("rel wr_en", wr_en, 1);
        check("rel wr_idx", wr_idx, 2);
        check("tb2 reads left", exp_idx.size(), 0);
        tick();
        sym_valid = 1'b0;
        @(negedge clk);
        check("post-rel write count", count, 10);
        check("wrap tb_req", tb_req, 1);
        check("wrap tb_start", tb_start, 1);
        check("wrap tb_len", tb_len, 6);
        tb_ack = 1'b1;
        push_tb(1, 6, 6, 2);
        tick();
        tb_ack = 1'b0;
        repeat (5) tick();
        sym_valid = 1'b1;
        @(negedge clk);
        check("wr+rel wr_en", wr_en, 1);
        check("wr+rel wr_idx", wr_idx, 3);
        check("wr+rel count before", count, 10);
        tick();
        sym_valid = 1'b0;
        @(negedge clk);
        check("wr+rel count after", count, 9);
        check("gap tb_req", tb_req, 0);
        check("tb3 reads left", exp_idx.size(), 0);
        tick();
        @(negedge clk);
        check("b2b tb_req", tb_req, 1);
        check("b2b tb_start", tb_start, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst in req tb_req", tb_req, 0);
        check("rst in req count", count, 0);
        check("rst in req wr_idx", wr_idx, 0);
        tick();

        sym_valid = 1'b1;
        repeat (3) tick();
        sym_valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        check("flush count", count, 3);
        check("flush tb_req before", tb_req, 0);
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("flush tb_req", tb_req, 1);
        check("flush tb_start", tb_start, 2);
        check("flush tb_len", tb_len, 3);
        tb_ack = 1'b1;
        push_tb(2, 3, 3, 3);
        tick();
        tb_ack = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("flush end count", count, 0);
        check("flush end rd_en", rd_en, 0);
        check("flush reads left", exp_idx.size(), 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("flush at zero ignored", tb_req, 0);
        tick();

        sym_valid = 1'b1;
        repeat (6) tick();
        sym_valid = 1'b0;
        @(negedge clk);
        check("mid count", count, 6);
        tick();
        @(negedge clk);
        check("mid tb_req", tb_req, 1);
        check("mid tb_start", tb_start, 8);
        tb_ack = 1'b1;
        push_tb(8, 2, 6, 2);
        tick();
        tb_ack = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("abort rd_en", rd_en, 0);
        check("abort count", count, 0);
        check("abort tb_req", tb_req, 0);
        check("abort sym_ready", sym_ready, 1);
        check("abort rd_onehot", rd_onehot, 0);
        check("abort reads left", exp_idx.size(), 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
